// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: NOP encoding, exception
// width and the per-entry layout {inst, pc, exception, badv}.
package inst_fetch_queue_pkg;

    localparam int FQ_EXC_W = 7;

    localparam logic [31:0] NOP_INST = 32'h0340_0000;

    // Exception code shared with the cache (instruction address fault)
    localparam logic [FQ_EXC_W-1:0] EXC_ADEF = 7'h08;

    localparam int ENTRY_W = 32 + 32 + FQ_EXC_W + 32;

    function automatic int entry_width(input int exc_w);
        return 32 + 32 + exc_w + 32;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_split.sv
// Splits one 64-bit fetch packet into up to two queue entries and reports
// how many of them are meaningful.
module fq_split
    import inst_fetch_queue_pkg::*;
#(
    parameter int EXC_W = FQ_EXC_W
) (
    input  logic [63:0]                   data,
    input  logic [31:0]                   pc,
    input  logic [EXC_W-1:0]              exception,
    input  logic [31:0]                   badv,
    output logic [1:0]                    n,
    output logic [entry_width(EXC_W)-1:0] entry0,
    output logic [entry_width(EXC_W)-1:0] entry1
);

    always_comb begin
        n      = 2'd1;
        entry0 = '0;
        entry1 = '0;
        if (exception != '0) begin
            // A faulting fetch carries no usable data; a NOP transports the fault
            entry0 = {NOP_INST, pc, exception, badv};
        end else if (!pc[2]) begin
            n      = 2'd2;
            entry0 = {data[31:0], pc, {EXC_W{1'b0}}, 32'h0};
            entry1 = {data[63:32], pc + 32'd4, {EXC_W{1'b0}}, 32'h0};
        end else begin
            entry0 = {data[63:32], pc, {EXC_W{1'b0}}, 32'h0};
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling queue between the instruction cache and the decoder: splits
// fetch packets into per-instruction entries and exposes the two oldest.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SLACK = 4,
    parameter int EXC_W = FQ_EXC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic [31:0]      in_pc,
    input  logic [EXC_W-1:0] in_exception,
    input  logic [31:0]      in_badv,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [31:0]      out0_inst,
    output logic [31:0]      out0_pc,
    output logic [EXC_W-1:0] out0_exception,
    output logic [31:0]      out0_badv,
    output logic             out1_valid,
    output logic [31:0]      out1_inst,
    output logic [31:0]      out1_pc,
    output logic [EXC_W-1:0] out1_exception,
    output logic [31:0]      out1_badv,
    input  logic [1:0]       pop,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = entry_width(EXC_W);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(SLACK);

    logic [EW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;

    logic [PTR_W-1:0] head_next, tail_next, tail_plus1;
    logic [CNT_W-1:0] count_next, pop_req, eff_pop, space;
    logic [1:0]       split_n, push_n, pop_sat;
    logic [EW-1:0]    split_e0, split_e1;
    logic             accept, drop;

    fq_split #(.EXC_W(EXC_W)) u_split (
        .data      (in_data),
        .pc        (in_pc),
        .exception (in_exception),
        .badv      (in_badv),
        .n         (split_n),
        .entry0    (split_e0),
        .entry1    (split_e1)
    );

    // Space counts slots freed by this cycle's pop, so a full queue being
    // drained can still take a packet.
    always_comb begin
        pop_sat    = (pop == 2'd3) ? 2'd2 : pop;
        pop_req    = CNT_W'(pop_sat);
        eff_pop    = (pop_req > count_reg) ? count_reg : pop_req;
        space      = DEPTH_C - count_reg + eff_pop;
        accept     = in_valid && !flush && (CNT_W'(split_n) <= space);
        drop       = in_valid && !flush && !accept;
        push_n     = accept ? split_n : 2'd0;
        count_next = count_reg + CNT_W'(push_n) - eff_pop;
        head_next  = head_reg + PTR_W'(eff_pop);
        tail_next  = tail_reg + PTR_W'(push_n);
        tail_plus1 = tail_reg + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_reg | drop;
        end
    end

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (rstn && push_n != 2'd0)
            mem[tail_reg] <= split_e0;
        if (rstn && push_n == 2'd2)
            mem[tail_plus1] <= split_e1;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [PTR_W-1:0] idx;
        logic             valid;
        logic [EW-1:0]    entry;
        assign idx   = head_reg + PTR_W'(gi);
        assign valid = count_reg > CNT_W'(gi);
        assign entry = valid ? mem[idx] : '0;
    end

    assign out0_valid = g_slot[0].valid;
    assign out1_valid = g_slot[1].valid;
    assign {out0_inst, out0_pc, out0_exception, out0_badv} = g_slot[0].entry;
    assign {out1_inst, out1_pc, out1_exception, out1_badv} = g_slot[1].entry;

    assign in_ready = (DEPTH_C - count_reg) >= SLACK_C;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small scoreboard for the
// streaming phase.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int EXC_W = FQ_EXC_W;

    logic             clk = 1'b0;
    logic             rstn, flush, in_valid;
    logic [63:0]      in_data;
    logic [31:0]      in_pc, in_badv;
    logic [EXC_W-1:0] in_exception;
    logic             in_ready, overflow;
    logic             out0_valid, out1_valid;
    logic [31:0]      out0_inst, out0_pc, out0_badv, out1_inst, out1_pc, out1_badv;
    logic [EXC_W-1:0] out0_exception, out1_exception;
    logic [1:0]       pop;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t sb[$];

    inst_fetch_queue #(.DEPTH(8), .SLACK(4), .EXC_W(EXC_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_pc          (in_pc),
        .in_exception   (in_exception),
        .in_badv        (in_badv),
        .in_ready       (in_ready),
        .out0_valid     (out0_valid),
        .out0_inst      (out0_inst),
        .out0_pc        (out0_pc),
        .out0_exception (out0_exception),
        .out0_badv      (out0_badv),
        .out1_valid     (out1_valid),
        .out1_inst      (out1_inst),
        .out1_pc        (out1_pc),
        .out1_exception (out1_exception),
        .out1_badv      (out1_badv),
        .pop            (pop),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs set before tick are sampled at the next edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        pop          = 2'd0;
        flush        = 1'b0;
        in_exception = '0;
        in_badv      = '0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [63:0] data);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = data;
    endtask

    initial begin
        int pushed, cycles, p, eff;
        logic [31:0] hi, lo, pc;

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; pop = 2'd0;
        in_data = '0; in_pc = '0; in_exception = '0; in_badv = '0;
        tick();
        tick();
        rstn = 1'b1;
        chk("rst_v0", out0_valid, 0);
        chk("rst_v1", out1_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_inst0", out0_inst, 0);

        // Aligned packet
        fetch(32'h1C00_0000, 64'h02800C21_02800421);
        tick();
        chk("al_inst0", out0_inst, 32'h02800421);
        chk("al_pc0", out0_pc, 32'h1C000000);
        chk("al_inst1", out1_inst, 32'h02800C21);
        chk("al_pc1", out1_pc, 32'h1C000004);
        chk("al_v0", out0_valid, 1);
        chk("al_v1", out1_valid, 1);
        chk("al_exc0", out0_exception, 0);
        pop = 2'd2;
        tick();
        chk("al_empty", out0_valid, 0);

        // Odd word
        fetch(32'h1C00_0004, 64'hAAAAAAAA_BBBBBBBB);
        tick();
        chk("odd_inst0", out0_inst, 32'hAAAAAAAA);
        chk("odd_pc0", out0_pc, 32'h1C000004);
        chk("odd_v1", out1_valid, 0);
        chk("odd_inst1_zero", out1_inst, 0);
        pop = 2'd1;
        tick();

        // Exception
        fetch(32'h1C00_0002, 64'h12345678_9ABCDEF0);
        in_exception = EXC_ADEF;
        in_badv      = 32'h1C00_0002;
        tick();
        chk("exc_inst", out0_inst, 32'h03400000);
        chk("exc_code", out0_exception, EXC_ADEF);
        chk("exc_badv", out0_badv, 32'h1C000002);
        chk("exc_pc", out0_pc, 32'h1C000002);
        chk("exc_v1", out1_valid, 0);
        pop = 2'd1;
        tick();

        // Fill to 7 with pop=0
        fetch(32'h100, 64'h00000011_00000010); tick();
        chk("fill2_ready", in_ready, 1);
        fetch(32'h108, 64'h00000013_00000012); tick();
        chk("fill4_ready", in_ready, 1);
        fetch(32'h114, 64'h00000015_000000FF); tick();
        chk("fill5_ready", in_ready, 0);
        fetch(32'h11C, 64'h00000017_000000FF); tick();
        fetch(32'h124, 64'h00000019_000000FF); tick();
        chk("fill7_ready", in_ready, 0);
        chk("fill7_ovf", overflow, 0);
        fetch(32'h128, 64'hEEEEEEEE_DDDDDDDD); tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_inst0", out0_inst, 32'h10);
        chk("ovf_inst1", out1_inst, 32'h11);
        pop = 2'd2; tick();
        chk("drain_a", out0_inst, 32'h12);
        pop = 2'd2; tick();
        chk("drain_b", out0_inst, 32'h15);
        chk("drain_b1", out1_pc, 32'h11C);
        pop = 2'd2; tick();
        chk("drain_c", out0_inst, 32'h19);
        chk("drain_c_v1", out1_valid, 0);
        chk("ovf_sticky", overflow, 1);
        flush = 1'b1; tick();
        chk("flush_ovf", overflow, 0);
        chk("flush_v0", out0_valid, 0);

        // Flush at count 6 with push and pop in the same cycle
        fetch(32'h180, 64'h1); tick();
        fetch(32'h188, 64'h2); tick();
        fetch(32'h190, 64'h3); tick();
        chk("c6_ready", in_ready, 0);
        fetch(32'h198, 64'h4);
        pop   = 2'd2;
        flush = 1'b1;
        tick();
        chk("fl_v0", out0_valid, 0);
        chk("fl_v1", out1_valid, 0);
        chk("fl_ready", in_ready, 1);
        fetch(32'h200, 64'h00000021_00000020); tick();
        chk("post_fl_inst0", out0_inst, 32'h20);
        chk("post_fl_pc0", out0_pc, 32'h200);
        pop = 2'd1; tick();
        chk("pop1_inst0", out0_inst, 32'h21);
        chk("pop1_v1", out1_valid, 0);
        pop = 2'd2; tick();
        chk("pop2_at1", out0_valid, 0);
        fetch(32'h20C, 64'h00000023_000000FF); tick();
        chk("after_pop2_inst", out0_inst, 32'h23);
        chk("after_pop2_v1", out1_valid, 0);
        fetch(32'h210, 64'h00000025_00000024); tick();
        pop = 2'd3; tick();
        chk("pop3_inst0", out0_inst, 32'h25);
        chk("pop3_v1", out1_valid, 0);
        pop = 2'd1; tick();
        chk("pop3_empty", out0_valid, 0);

        // Stream with scoreboard
        pushed = 0;
        cycles = 0;
        while ((pushed < 40 || sb.size() > 0) && cycles < 600) begin
            p   = cycles % 4;
            eff = (p == 3) ? 2 : p;
            if (eff > sb.size()) eff = sb.size();
            chk("st_v0", out0_valid, (sb.size() >= 1) ? 1 : 0);
            chk("st_v1", out1_valid, (sb.size() >= 2) ? 1 : 0);
            if (eff >= 1) begin
                chk("st_inst0", out0_inst, sb[0].inst);
                chk("st_pc0", out0_pc, sb[0].pc);
            end
            if (eff == 2) begin
                chk("st_inst1", out1_inst, sb[1].inst);
                chk("st_pc1", out1_pc, sb[1].pc);
            end
            pop = 2'(p);
            for (int k = 0; k < eff; k++) void'(sb.pop_front());
            if (pushed < 40 && in_ready) begin
                pc = 32'h4000_0000 + 32'(pushed * 8) + (((pushed % 3) == 1) ? 32'd4 : 32'd0);
                hi = 32'hA000_0001 + 32'(pushed << 8);
                lo = 32'hB000_0000 + 32'(pushed << 8);
                fetch(pc, {hi, lo});
                if (pc[2]) begin
                    sb.push_back('{hi, pc});
                end else begin
                    sb.push_back('{lo, pc});
                    sb.push_back('{hi, pc + 32'd4});
                end
                pushed++;
            end
            tick();
            cycles++;
        end
        chk("stream_pushed", pushed, 40);
        chk("stream_drained", sb.size(), 0);
        chk("stream_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling queue directly downstream of the instruction cache.
- Accepts one 64-bit fetch packet per cycle (up to two 32-bit instructions) with PC, exception and bad-address information, and splits it into per-instruction entries.
- Presents the two oldest entries to the decoder, which pops 0, 1 or 2 per cycle.
- Produces the backpressure signal that gates new fetch requests into the cache.

Parameters:
- DEPTH, 8: entries (one instruction each); power of two, at least 4.
- SLACK, 4: minimum free entries required for in_ready; covers the accepted packet plus one in flight.
- EXC_W, 7: exception code width; matches the cache exception output.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  discard all entries (branch redirect or exception)
- in_valid  in  1  fetch packet valid (cache data_valid)
- in_data  in  64  packet; [31:0] at pc&~7, [63:32] at (pc&~7)+4
- in_pc  in  32  PC of first requested instruction
- in_exception  in  EXC_W  nonzero means fetch exception
- in_badv  in  32  faulting address
- in_ready  out  1  free >= SLACK; the upstream issues new fetches only while high
- out0_valid, out1_valid  out  1 each  head / head+1 entry present
- out0_inst, out1_inst  out  32 each  instruction
- out0_pc, out1_pc  out  32 each  instruction PC
- out0_exception, out1_exception  out  EXC_W each  exception code
- out0_badv, out1_badv  out  32 each  bad address
- pop  in  2  entries consumed this cycle (0..2)
- overflow  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk; reset rstn is synchronous and active-low.
- Reset values: head=tail=0, count=0, all outN_valid=0, overflow=0, in_ready=1.
- Entry format: {inst, pc, exception, badv}. Storage is a DEPTH-entry array with head/tail pointers modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- Push count n, decided on in_valid with flush low:
  - exception != 0: n=1. The entry is {NOP 32'h03400000, in_pc, in_exception, in_badv}.
  - else in_pc[2]=0: n=2. The entries are {in_data[31:0], in_pc} then {in_data[63:32], in_pc+4}, with exception=0 and badv=0.
  - else in_pc[2]=1: n=1. The entry is {in_data[63:32], in_pc}.
- Overflow: if n > DEPTH - count + effective_pop, the whole packet is dropped (no partial push) and overflow is set. overflow clears only on reset or flush.
- Effective pop: min(pop, count). pop=3 is treated as 2. Popping from an empty queue is a no-op.
- Simultaneous push and pop: count_next = count + n - effective_pop. Pushed entries are written at tail and tail+1 modulo DEPTH.
- Latency: registered storage with no bypass. A packet pushed in cycle t is visible on outN in cycle t+1.
- Output view:
  - out0 = entry[head]; out1 = entry[head+1 mod DEPTH].
  - out0_valid = (count >= 1); out1_valid = (count >= 2).
  - Invalid slots drive zero data.
- in_ready is combinational from registered count: (DEPTH - count) >= SLACK.
- Flush:
  - Highest priority; the same-cycle push and pop are ignored.
  - Next cycle: count=0, head=tail=0, valids=0, overflow=0.
- Reset mid-operation behaves identically to flush and is synchronous only.
- Wrap-around: the pointers wrap naturally. Full (count=DEPTH) and empty (count=0) are distinguished by count, not by pointer equality.

Decomposition:
- Shared package/header: NOP encoding, EXC_W, and the entry-width constant. Exception codes come from the existing exception header.
- Sub-module fq_split: combinational packet-to-entries splitter (n, entry0, entry1).
- Pointer, count and array logic stay in the top module.

Test Plan:
1. Aligned packet: in_pc=0x1C000000, in_data=0x02800C21_02800421. Next cycle: out0={0x02800421, 0x1C000000}, out1={0x02800C21, 0x1C000004}, both valid, count=2.
2. Odd word: in_pc=0x1C000004, in_data=0xAAAAAAAA_BBBBBBBB. Next cycle: out0={0xAAAAAAAA, 0x1C000004}, out1_valid=0.
3. Exception: in_pc=0x1C000002, in_exception=ADEF, in_badv=0x1C000002. Result: a single entry with inst=0x03400000, exception=ADEF, badv=0x1C000002.
4. Fill with pop=0 and DEPTH=8:
   - in_ready drops once count reaches 5.
   - Pushing an aligned packet at count=7 sets overflow; count stays 7 and stored entries are unchanged.
   - A following flush clears overflow.
5. Flush at count=6 with a simultaneous aligned push and pop=2. Next cycle: count=0, valids=0, in_ready=1. Later pushes start at entry 0.
6. Stream 40 packets with mixed alignment while pop cycles through 0/1/2/3:
   - Sequence order is preserved across wrap-around.
   - pop=2 at count=1 pops exactly one entry.
   - pop=3 behaves as 2.
   - A reference-model scoreboard matches every popped entry.
